// File: rtl/load_align_unit.sv
// Load alignment unit: issues aligned memory reads for MIPS byte/half/word loads,
// tracks outstanding loads in order, and extracts/extends the addressed lane on return.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              flush,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              adel,
  output logic [31:0]       adel_addr,
  output logic              spurious_rsp
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] ADDR_MASK = ~32'(DATA_W / 8 - 1);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;

  localparam logic [2:0] K_LB  = 3'd0;
  localparam logic [2:0] K_LH  = 3'd1;
  localparam logic [2:0] K_LW  = 3'd2;
  localparam logic [2:0] K_LBU = 3'd3;
  localparam logic [2:0] K_LHU = 3'd4;

  function automatic logic [2:0] decode_op(input logic [5:0] op);
    case (op)
      OP_LB:   decode_op = K_LB;
      OP_LH:   decode_op = K_LH;
      OP_LBU:  decode_op = K_LBU;
      OP_LHU:  decode_op = K_LHU;
      default: decode_op = K_LW;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] kind, input logic [1:0] a);
    case (kind)
      K_LH, K_LHU: is_misaligned = a[0];
      K_LW:        is_misaligned = (a != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Shifting the whole beat by the byte offset puts the addressed lane at bit 0,
  // which works for any lane size because the access is already known to be aligned.
  function automatic logic [31:0] extract(input logic [2:0] kind,
                                          input logic [OFF_W-1:0] off,
                                          input logic [DATA_W-1:0] data);
    logic [31:0] sh;
    sh = 32'(data >> {off, 3'b000});
    case (kind)
      K_LB:    extract = {{24{sh[7]}}, sh[7:0]};
      K_LBU:   extract = {24'd0, sh[7:0]};
      K_LH:    extract = {{16{sh[15]}}, sh[15:0]};
      K_LHU:   extract = {16'd0, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  logic [2:0]       q_kind [DEPTH];
  logic [OFF_W-1:0] q_off  [DEPTH];
  logic [4:0]       q_rd   [DEPTH];
  logic [DEPTH-1:0] q_kill;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic       full, vld_p0, bad_p0, push, pop, drop, wb_load;
  logic [2:0] kind_p0;

  // Stage p0: request decode and queue control
  assign full      = (count == CNT_W'(DEPTH));
  assign req_ready = !full && !(mem_req_valid && !mem_req_ready) && !flush;
  assign vld_p0    = req_valid && req_ready;
  assign kind_p0   = decode_op(req_op);
  assign bad_p0    = is_misaligned(kind_p0, req_addr[1:0]);
  assign push      = vld_p0 && !bad_p0;
  assign pop       = mem_rsp_valid && (count != '0);
  assign drop      = flush && mem_req_valid && !mem_req_ready &&
                     !(pop && count == CNT_W'(1));
  assign wb_load   = pop && !q_kill[rd_ptr] && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      q_kind[wr_ptr] <= kind_p0;
      q_off[wr_ptr]  <= req_addr[OFF_W-1:0];
      q_rd[wr_ptr]   <= req_rd;
    end
  end

  // Stage p1: registered memory request, writeback and exception outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      q_kill        <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_rd         <= '0;
      adel          <= 1'b0;
      adel_addr     <= '0;
      spurious_rsp  <= 1'b0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop) - CNT_W'(drop);
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      else if (drop)
        wr_ptr <= wr_ptr - PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);

      if (flush)
        q_kill <= '1;
      else if (push)
        q_kill[wr_ptr] <= 1'b0;

      if (push) begin
        mem_req_valid <= 1'b1;
        mem_addr      <= req_addr & ADDR_MASK;
      end else if (mem_req_valid && (mem_req_ready || flush)) begin
        mem_req_valid <= 1'b0;
      end

      wb_valid <= wb_load;
      if (wb_load) begin
        wb_data <= extract(q_kind[rd_ptr], q_off[rd_ptr], mem_rsp_data);
        wb_rd   <= q_rd[rd_ptr];
      end

      adel <= vld_p0 && bad_p0;
      if (vld_p0 && bad_p0)
        adel_addr <= req_addr;

      if (mem_rsp_valid && count == '0)
        spurious_rsp <= 1'b1;
    end
  end

endmodule

// File: doc/load_align_unit.md
LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data width in bits; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 4, maximum outstanding loads; power of two, 2..16.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: load-request handshake.
REQ-006 SHALL have ports req_op in 6 (MIPS opcode), req_addr in 32 (byte address), req_rd in 5 (destination register).
REQ-007 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_addr out 32: memory read request.
REQ-008 SHALL have ports mem_rsp_valid in 1, mem_rsp_data in DATA_W: in-order memory read response, no backpressure.
REQ-009 SHALL have ports flush in 1: discard all not-yet-written-back loads.
REQ-010 SHALL have ports wb_valid out 1, wb_data out 32, wb_rd out 5: writeback result, single-cycle pulse.
REQ-011 SHALL have ports adel out 1, adel_addr out 32: address-error exception pulse and faulting address.
REQ-012 SHALL have port spurious_rsp out 1: sticky flag, response received with no pending load.

Function
REQ-013 Opcodes: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101; any other opcode SHALL be handled as LW.
REQ-014 A request SHALL be accepted on a cycle with req_valid && req_ready.
REQ-015 req_ready SHALL equal !full && !(mem_req_valid && !mem_req_ready) && !flush.
REQ-016 Alignment: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, SHALL NOT issue memory traffic or enter the pending queue.
REQ-017 A misaligned accepted request SHALL assert adel for exactly one cycle, the cycle after acceptance, with adel_addr = req_addr.
REQ-018 An aligned accepted request SHALL push {op, lane offset, rd, kill=0} into a DEPTH-entry pending FIFO and register mem_req_valid=1 next cycle.
REQ-019 mem_addr SHALL equal req_addr with its low log2(DATA_W/8) bits cleared; mem_addr and mem_req_valid SHALL hold until mem_req_ready=1.
REQ-020 Each mem_rsp_valid SHALL pop the FIFO head; responses match requests strictly in order.
REQ-021 Extraction: byte lane = offset; LB/LH SHALL sign-extend to 32 bits, LBU/LHU SHALL zero-extend; LW SHALL return the 32-bit word at offset; little-endian lane order.
REQ-022 For DATA_W=64, offset SHALL be addr[2:0] and select among 8 byte lanes / 4 half lanes / 2 word lanes.
REQ-023 wb_valid, wb_data, wb_rd SHALL be registered, asserted exactly 1 cycle after the mem_rsp_valid cycle, for a non-killed head entry.
REQ-024 A popped head entry with kill=1 SHALL produce no wb_valid.
REQ-025 flush SHALL set kill=1 on every FIFO entry, drop an un-handshaken mem request only if mem_req_ready=0 that cycle (popping its entry), and suppress a same-cycle wb_valid register load.
REQ-026 Simultaneous push and pop SHALL keep occupancy unchanged; full = (count == DEPTH); pointers SHALL wrap modulo DEPTH.
REQ-027 mem_rsp_valid with FIFO empty SHALL be ignored and SHALL set spurious_rsp until reset.
REQ-028 Only one memory request SHALL be outstanding in the request register; further outstanding loads live only in the FIFO.

Reset
REQ-029 rst=1 SHALL immediately clear req_ready-related state, FIFO count/pointers, mem_req_valid, wb_valid, adel, spurious_rsp to 0; wb_data, wb_rd, adel_addr, mem_addr to 0.
REQ-030 Reset mid-operation SHALL abandon all pending loads; responses arriving after reset release SHALL be treated per REQ-027.
REQ-031 req_ready SHALL be 1 on the first cycle after reset release (absent flush).

Verification
REQ-032 LB addr 0x1003, rsp data 0x80FF_1234 -> wb_data 0xFFFF_FF80, wb_rd as issued, wb_valid 1 cycle after rsp.
REQ-033 LHU addr 0x2002, rsp 0xBEEF_0000 -> wb_data 0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-034 LW addr 0x3002 -> adel pulse next cycle, adel_addr 0x3002, no mem_req_valid, no wb_valid.
REQ-035 DATA_W=64, DEPTH=2: LW 0x8004 with mem_req_ready held 0 for 3 cycles -> mem_addr 0x8000 held; rsp upper word returned; third request stalls (req_ready=0) until a pop.
REQ-036 Two loads pending, flush, then two responses -> no wb_valid; next load completes normally.
REQ-037 mem_rsp_valid with empty FIFO -> spurious_rsp=1 stays set until rst; rst mid-load clears all outputs asynchronously.
